// File: rtl/rx_sample_delay.sv
// rx_sample_delay: runtime-programmable multi-channel IQ sample delay, counted in valid samples; ports: clk_i, reset_ni (async active-low), delay_i/delay_load_i (delay programming), s_axis_in_* (input stream), m_axis_out_* (delayed stream), fill_level_o, delay_active_o, filling_o; RX_SAMPLE_DELAY_STATS_EN adds drop_cnt_o
module rx_sample_delay #(
  parameter int IN_DW = 32,
  parameter int N_CH = 1,
  parameter int MAX_DELAY = 64,
  parameter int RESET_DELAY = 16,
  localparam int DELAY_W = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [DELAY_W-1:0]    delay_i,
  input  logic                  delay_load_i,
  input  logic [N_CH*IN_DW-1:0] s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  output logic [N_CH*IN_DW-1:0] m_axis_out_tdata,
  output logic                  m_axis_out_tvalid,
  output logic [DELAY_W-1:0]    fill_level_o,
  output logic [DELAY_W-1:0]    delay_active_o,
  output logic                  filling_o
`ifdef RX_SAMPLE_DELAY_STATS_EN
  ,
  output logic [15:0]           drop_cnt_o
`endif
);
  localparam int AW = MAX_DELAY > 1 ? $clog2(MAX_DELAY) : 1;
  localparam int PW = DELAY_W + 1;
  localparam int DW = N_CH * IN_DW;
  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_n;
  logic [DW-1:0] mem [MAX_DELAY];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DELAY_W-1:0] d_sat, d_n, fill_n;
  logic emit;
  assign d_sat = delay_i > DELAY_W'(MAX_DELAY) ? DELAY_W'(MAX_DELAY) : delay_i;
  assign d_n = delay_load_i ? d_sat : delay_active_o;
  // a load restarts the count; a same-cycle sample opens the new fill unless the new delay is zero
  assign fill_n = delay_load_i ? DELAY_W'(s_axis_in_tvalid && d_sat != '0) :
                  (state == FILL && s_axis_in_tvalid) ? fill_level_o + 1'b1 : fill_level_o;
  assign emit = s_axis_in_tvalid && (delay_load_i ? d_sat == '0 : state == RUN);
  // wr_ptr - D modulo a depth that need not be a power of two
  assign rd_ptr = AW'(PW'(wr_ptr) + (PW'(wr_ptr) >= PW'(delay_active_o) ? PW'(0) : PW'(MAX_DELAY))
                  - PW'(delay_active_o));
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state <= RESET_DELAY == 0 ? RUN : FILL;
    else state <= state_n;
  always_comb state_n = fill_n == d_n ? RUN : FILL;
  always_comb filling_o = state == FILL;
  // buffer slots are never read before being refilled, so they need no reset
  always_ff @(posedge clk_i)
    if (s_axis_in_tvalid) mem[wr_ptr] <= s_axis_in_tdata;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      wr_ptr <= '0;
      fill_level_o <= '0;
      delay_active_o <= DELAY_W'(RESET_DELAY);
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tdata <= '0;
    end else begin
      if (s_axis_in_tvalid) wr_ptr <= wr_ptr == AW'(MAX_DELAY - 1) ? '0 : wr_ptr + 1'b1;
      fill_level_o <= fill_n;
      delay_active_o <= d_n;
      m_axis_out_tvalid <= emit;
      if (emit) m_axis_out_tdata <= (delay_load_i || delay_active_o == '0) ? s_axis_in_tdata : mem[rd_ptr];
    end
`ifdef RX_SAMPLE_DELAY_STATS_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt_o} + 17'(fill_level_o);
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) drop_cnt_o <= '0;
    else if (delay_load_i) drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`endif
endmodule
